// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect and decode handshake.
// The master modport is the fetch unit's view; slave is the surrounding environment.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    output instr_valid,
    output instr,
    output instr_pc,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, in-order memory requests, response buffering
// into a first-word-fall-through FIFO, and redirect flush of buffered and in-flight fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = CW + 1;
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);
  localparam logic [OW-1:0] DepthO = OW'(FIFO_DEPTH);

  logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]   r_resp_pc,  w_resp_pc_nxt;
  logic [CW-1:0] r_out_cnt,  w_out_cnt_nxt;
  logic [CW-1:0] r_drop_cnt, w_drop_cnt_nxt;
  logic [CW-1:0] r_count,    w_count_nxt;
  logic [AW-1:0] r_wptr,     w_wptr_nxt;
  logic [AW-1:0] r_rptr,     w_rptr_nxt;
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];

  logic [CW-1:0] w_kept;
  logic [OW-1:0] w_occ;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_instr_valid;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_redirect_pc;

  // Requests still owed a FIFO slot plus entries already buffered.
  assign w_kept = r_out_cnt - r_drop_cnt;
  assign w_occ  = {1'b0, w_kept} + {1'b0, r_count};

  // Gating with rst keeps the request quiet while reset is held.
  assign w_req_valid = rst && !bus.redirect_valid && (w_occ < DepthO) && (r_out_cnt < DepthC);
  assign w_accept    = w_req_valid && bus.imem_req_ready;

  assign w_instr_valid = (r_count != '0);
  assign w_pop         = w_instr_valid && bus.instr_ready;
  assign w_push        = bus.imem_resp_valid && (r_drop_cnt == '0) && !bus.redirect_valid;
  assign w_redirect_pc = bus.redirect_pc & ~32'h3;

  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    w_resp_pc_nxt  = r_resp_pc;
    w_out_cnt_nxt  = r_out_cnt + CW'(w_accept) - CW'(bus.imem_resp_valid);
    w_drop_cnt_nxt = r_drop_cnt;
    w_count_nxt    = r_count;
    w_wptr_nxt     = r_wptr;
    w_rptr_nxt     = r_rptr;

    if (bus.redirect_valid) begin
      // Everything in flight at this point belongs to the abandoned stream.
      w_fetch_pc_nxt = w_redirect_pc;
      w_resp_pc_nxt  = w_redirect_pc;
      w_drop_cnt_nxt = r_out_cnt - CW'(bus.imem_resp_valid);
      w_count_nxt    = '0;
      w_wptr_nxt     = '0;
      w_rptr_nxt     = '0;
    end else begin
      if (w_accept) begin
        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
      end
      if (bus.imem_resp_valid && (r_drop_cnt != '0)) begin
        w_drop_cnt_nxt = r_drop_cnt - CW'(1);
      end
      if (w_push) begin
        w_resp_pc_nxt = r_resp_pc + 32'd4;
        w_wptr_nxt    = r_wptr + AW'(1);
      end
      if (w_pop) begin
        w_rptr_nxt = r_rptr + AW'(1);
      end
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_resp_pc  <= w_resp_pc_nxt;
      r_out_cnt  <= w_out_cnt_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
      r_count    <= w_count_nxt;
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
    end
  end

  // Storage needs no reset: r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]   <= r_resp_pc;
      r_fifo_data[r_wptr] <= bus.imem_resp_data;
    end
  end

  always_comb begin
    bus.imem_req_valid = w_req_valid;
    bus.imem_req_addr  = r_fetch_pc;
    bus.instr_valid    = w_instr_valid;
    bus.instr          = NOP_INSTR;
    bus.instr_pc       = 32'h0;
    if (w_instr_valid) begin
      bus.instr    = r_fifo_data[r_rptr];
      bus.instr_pc = r_fifo_pc[r_rptr];
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: an in-order memory model with epoch-tagged
// requests predicts kept responses; a separate monitor checks every decode handshake.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          D      = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(D),
    .NOP_INSTR (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] mpc;
    int unsigned epoch;
    int unsigned due;
  } req_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  req_t        mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] acc_log[$];
  int unsigned epoch = 0;
  int unsigned cyc = 0;
  logic [31:0] model_pc = RST_PC;
  int          total = 0;
  int          bad = 0;

  int lat_min = 1, lat_max = 1, rdy_pct = 100, req_pct = 100, redir_pct = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc = '0;
  bit          resp_kept = 1'b0;
  bit          stepped = 1'b0;
  bit          arm_first = 1'b0;
  bit          want_first = 1'b0;
  logic [31:0] want_pc = '0;
  int          n_fifo;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of environment: redirect, memory response, handshake inputs, request accept.
  task automatic step();
    int          kept_in_mem;
    bit          resp_now;
    bit          exp_rv;
    logic [31:0] rpc;
    req_t        r;
    @(negedge clk);
    cyc++;
    bus.redirect_valid = 1'b0;
    if (force_redir || ($urandom_range(0, 99) < redir_pct)) begin
      if (force_redir) rpc = force_pc;
      else if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else rpc = $urandom;
      force_redir        = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = rpc;
      epoch++;
      model_pc = rpc & ~32'h3;
      acc_log.delete();
    end
    resp_now            = 1'b0;
    resp_kept           = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = $urandom;
    if (mem_q.size() > 0 && cyc >= mem_q[0].due) begin
      r = mem_q.pop_front();
      resp_now            = 1'b1;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = memfn(r.mpc);
      if (r.epoch == epoch) begin
        exp_q.push_back('{pc: r.mpc, data: memfn(r.mpc)});
        resp_kept = 1'b1;
      end
    end
    bus.instr_ready    = ($urandom_range(0, 99) < rdy_pct);
    bus.imem_req_ready = ($urandom_range(0, 99) < req_pct);
    #2;
    kept_in_mem = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch == epoch) kept_in_mem++;
    exp_rv = !bus.redirect_valid && (kept_in_mem + exp_q.size() < D) &&
             (mem_q.size() + int'(resp_now) < D);
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("req_addr", bus.imem_req_addr, model_pc);
      acc_log.push_back(bus.imem_req_addr);
      mem_q.push_back('{mpc: model_pc, epoch: epoch,
                        due: cyc + $urandom_range(lat_min, lat_max)});
      model_pc = model_pc + 32'd4;
    end
    stepped = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #4;
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_req_addr", bus.imem_req_addr, RST_PC);
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid  = 1'b0;
    mem_q.delete();
    exp_q.delete();
    acc_log.delete();
    epoch++;
    model_pc   = RST_PC;
    resp_kept  = 1'b0;
    want_first = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    force_redir = 1'b1;
    force_pc    = pc;
    arm_first   = 1'b1;
    step();
  endtask

  // Monitor: compares every decode handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst && stepped) begin
        stepped = 1'b0;
        n_fifo  = exp_q.size() - int'(resp_kept);
        chk("instr_valid", 32'(bus.instr_valid), 32'(n_fifo > 0));
        if (bus.instr_valid && bus.instr_ready && n_fifo > 0) begin
          e = exp_q.pop_front();
          chk("instr_pc", bus.instr_pc, e.pc);
          chk("instr", bus.instr, e.data);
          if (want_first) begin
            chk("first_pc_after_redirect", bus.instr_pc, want_pc);
            want_first = 1'b0;
          end
        end else if (!bus.instr_valid) begin
          chk("idle_instr", bus.instr, NOP);
          chk("idle_pc", bus.instr_pc, 32'h0);
        end
        if (bus.redirect_valid) begin
          exp_q.delete();
          if (arm_first) begin
            want_first = 1'b1;
            want_pc    = bus.redirect_pc & ~32'h3;
            arm_first  = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int first_valid;
    int n_valid;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.instr_ready     = 1'b0;
    #1;
    chk("por_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("por_instr", bus.instr, NOP);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Streaming with 1-cycle memory: first instruction in cycle 3, then one per cycle.
    first_valid = 0;
    n_valid     = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
      if (bus.instr_valid) begin
        n_valid++;
        if (first_valid == 0) first_valid = k;
      end
    end
    chk("first_instr_cycle", 32'(first_valid), 32'd3);
    chk("throughput", 32'(n_valid), 32'd18);

    // Decode stalled from reset: only D requests fit, then drain and resume at 0x10.
    do_reset();
    rdy_pct = 0;
    repeat (10) step();
    chk("stall_accepts", 32'(acc_log.size()), 32'(D));
    rdy_pct = 100;
    repeat (10) step();
    if (acc_log.size() > 4) chk("resume_addr", acc_log[4], 32'h10);
    else chk("resume_addr_seen", 32'(acc_log.size()), 32'd5);

    // Reset with a full buffer.
    rdy_pct = 0;
    repeat (8) step();
    chk("full_before_reset", 32'(bus.instr_valid), 32'd1);
    do_reset();
    rdy_pct = 100;
    repeat (6) step();

    // Slow memory, two requests outstanding, redirect to 0x100.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    repeat (2) step();
    chk("outstanding_before_redirect", 32'(mem_q.size()), 32'd2);
    redirect_to(32'h0000_0100);
    repeat (12) step();
    chk("first_pc_seen", 32'(want_first), 32'd0);

    // Redirect coinciding with a response and a pop in a steady stream.
    lat_min = 1;
    lat_max = 1;
    repeat (6) step();
    redirect_to(32'h0000_0400);
    repeat (8) step();

    // Unaligned redirect target.
    redirect_to(32'h0000_0203);
    step();
    if (acc_log.size() > 0) chk("aligned_addr", acc_log[0], 32'h200);
    else chk("aligned_addr_seen", 32'(acc_log.size()), 32'd1);
    repeat (6) step();

    // Address wrap.
    redirect_to(32'hFFFF_FFF8);
    repeat (6) step();
    if (acc_log.size() > 2) begin
      chk("wrap_a0", acc_log[0], 32'hFFFF_FFF8);
      chk("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
      chk("wrap_a2", acc_log[2], 32'h0000_0000);
    end else begin
      chk("wrap_seen", 32'(acc_log.size()), 32'd3);
    end
    repeat (4) step();

    // Randomized traffic with redirects, stalls and variable latency.
    lat_min   = 1;
    lat_max   = 4;
    rdy_pct   = 70;
    req_pct   = 80;
    redir_pct = 5;
    for (int k = 0; k < 1500; k++) begin
      step();
      if (k == 700) begin
        redir_pct = 0;
        do_reset();
        redir_pct = 5;
      end
    end
    redir_pct = 0;
    rdy_pct   = 100;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
